// File: rtl/hust_efi_pkg.sv
// Shared HUST EFI definitions: wheel geometry default, crank FSM states and
// the tooth-period ratio used to recognise the missing-tooth gap.
`ifndef CFG_CRANK_TEETH
`define CFG_CRANK_TEETH 36
`endif

package hust_efi_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_FIRST    = 2'd1,
    ST_SEEK_GAP = 2'd2,
    ST_SYNCED   = 2'd3
  } crank_state_t;

  // An edge is a gap when cur/prev > NUM/DEN, tested as cur*DEN > prev*NUM.
  localparam int unsigned GAP_RATIO_NUM = 3;
  localparam int unsigned GAP_RATIO_DEN = 2;

endpackage

// File: rtl/crank_decoder_if.sv
// Crank-position bundle from crank_decoder to the stroke-transition logic.
// The decoder drives it through 'master'; consumers read it through 'slave'.
interface crank_decoder_if #(
  parameter int TEETH    = `CFG_CRANK_TEETH,
  parameter int PERIOD_W = 20
);
  localparam int POS_W = $clog2(2 * TEETH);

  logic                crank_tick;
  logic                crank_changed;
  logic [POS_W-1:0]    crank_pos;
  logic                sync;
  logic                sync_err;
  logic                running;
  logic [PERIOD_W-1:0] tooth_period;

  modport master (
    output crank_tick, crank_changed, crank_pos, sync, sync_err, running, tooth_period
  );

  modport slave (
    input crank_tick, crank_changed, crank_pos, sync, sync_err, running, tooth_period
  );
endinterface

// File: rtl/ckp_edge_filter.sv
// CKP input conditioning: 2-flop synchronizer, optional glitch filter
// (CKP_GLITCH_FILTER_EN) and a registered one-cycle rising-edge pulse.
module ckp_edge_filter #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ckp,
  output logic edge_pulse
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic lvl;
  logic lvl_prev_q, lvl_prev_d;
  logic rise_q, rise_d;

`ifdef CKP_GLITCH_FILTER_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  // The accepted level flips only after DEB_CYCLES consecutive opposite samples.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d  = '0;
    filt_d = filt_q;
    if (s2_q != filt_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        filt_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign lvl = filt_q;
`else
  logic unused_deb;

  assign unused_deb = (DEB_CYCLES != 0);
  assign lvl        = s2_q;
`endif

  always_comb begin
    s1_d       = ckp;
    s2_d       = s1_q;
    lvl_prev_d = lvl;
    rise_d     = lvl & ~lvl_prev_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      lvl_prev_q <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      lvl_prev_q <= lvl_prev_d;
      rise_q     <= rise_d;
    end
  end

  assign edge_pulse = rise_q;

endmodule

// File: rtl/crank_decoder.sv
// Crank-position decoder: tooth-period measurement, missing-tooth gap lock and
// 720-degree position tracking. CKP_GLITCH_FILTER_EN enables the input filter.
module crank_decoder
  import hust_efi_pkg::*;
#(
  parameter int          TEETH        = `CFG_CRANK_TEETH,
  parameter int          MISSING      = 1,
  parameter int          PERIOD_W     = 20,
  parameter int unsigned STALL_CYCLES = 2**20 - 1,
  parameter int          DEB_CYCLES   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ckp,
  crank_decoder_if.master   crank
);

  localparam int POS_W   = $clog2(2 * TEETH);
  localparam int TOOTH_W = $clog2(TEETH);
  localparam int GAP_W   = PERIOD_W + 2;

  localparam logic [TOOTH_W-1:0]  LAST_TOOTH = TOOTH_W'(TEETH - MISSING - 1);
  localparam logic [PERIOD_W-1:0] STALL_LIM  = PERIOD_W'(STALL_CYCLES);

  logic edge_pulse;

  ckp_edge_filter #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_edge (
    .clk        (clk),
    .reset      (reset),
    .ckp        (ckp),
    .edge_pulse (edge_pulse)
  );

  crank_state_t        state_q, state_d;
  logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
  logic [PERIOD_W-1:0] tooth_period_q, tooth_period_d;
  logic [TOOTH_W-1:0]  tooth_q, tooth_d;
  logic                rev_q, rev_d;
  logic [POS_W-1:0]    crank_pos_q, crank_pos_d;
  logic                tick_q, tick_d;
  logic                changed_q, changed_d;
  logic                err_q, err_d;
  logic                sync_q, sync_d;
  logic                running_q, running_d;

  logic [GAP_W-1:0] cur_scaled;
  logic [GAP_W-1:0] prev_scaled;
  logic             is_gap;
  logic             stall;

  // Widened so both scaled periods fit without overflow.
  assign cur_scaled  = GAP_W'(per_cnt_q) * GAP_W'(GAP_RATIO_DEN);
  assign prev_scaled = GAP_W'(tooth_period_q) * GAP_W'(GAP_RATIO_NUM);
  assign is_gap      = cur_scaled > prev_scaled;

  // A simultaneous edge restarts the period count, so the edge wins.
  assign stall = !edge_pulse && (per_cnt_q >= STALL_LIM);

  always_comb begin
    per_cnt_d = per_cnt_q;
    if (edge_pulse) begin
      per_cnt_d = PERIOD_W'(1);
    end else if (per_cnt_q != '1) begin
      per_cnt_d = per_cnt_q + PERIOD_W'(1);
    end
  end

  always_comb begin
    state_d        = state_q;
    tooth_d        = tooth_q;
    rev_d          = rev_q;
    tooth_period_d = tooth_period_q;
    crank_pos_d    = crank_pos_q;
    tick_d         = 1'b0;
    changed_d      = 1'b0;
    err_d          = 1'b0;

    if (stall) begin
      state_d        = ST_STOPPED;
      tooth_d        = '0;
      rev_d          = 1'b0;
      tooth_period_d = '0;
    end else if (edge_pulse) begin
      tick_d         = 1'b1;
      tooth_period_d = per_cnt_q;
      unique case (state_q)
        ST_STOPPED: state_d = ST_FIRST;
        ST_FIRST:   state_d = ST_SEEK_GAP;
        ST_SEEK_GAP: begin
          if (is_gap) begin
            state_d   = ST_SYNCED;
            tooth_d   = '0;
            rev_d     = 1'b0;
            changed_d = 1'b1;
          end
        end
        ST_SYNCED: begin
          // A gap is legal exactly at the last physical tooth, and only there.
          if (is_gap == (tooth_q == LAST_TOOTH)) begin
            changed_d = 1'b1;
            if (is_gap) begin
              tooth_d = '0;
              rev_d   = ~rev_q;
            end else begin
              tooth_d = tooth_q + TOOTH_W'(1);
            end
          end else begin
            err_d   = 1'b1;
            state_d = ST_SEEK_GAP;
          end
        end
        default: state_d = ST_STOPPED;
      endcase
    end

    if (stall) begin
      crank_pos_d = '0;
    end else if (changed_d) begin
      crank_pos_d = rev_d ? POS_W'(TEETH) + POS_W'(tooth_d) : POS_W'(tooth_d);
    end

    sync_d    = (state_d == ST_SYNCED);
    running_d = (state_d != ST_STOPPED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_STOPPED;
      per_cnt_q      <= '0;
      tooth_period_q <= '0;
      tooth_q        <= '0;
      rev_q          <= 1'b0;
      crank_pos_q    <= '0;
      tick_q         <= 1'b0;
      changed_q      <= 1'b0;
      err_q          <= 1'b0;
      sync_q         <= 1'b0;
      running_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      per_cnt_q      <= per_cnt_d;
      tooth_period_q <= tooth_period_d;
      tooth_q        <= tooth_d;
      rev_q          <= rev_d;
      crank_pos_q    <= crank_pos_d;
      tick_q         <= tick_d;
      changed_q      <= changed_d;
      err_q          <= err_d;
      sync_q         <= sync_d;
      running_q      <= running_d;
    end
  end

  assign crank.crank_tick    = tick_q;
  assign crank.crank_changed = changed_q;
  assign crank.crank_pos     = crank_pos_q;
  assign crank.sync          = sync_q;
  assign crank.sync_err      = err_q;
  assign crank.running       = running_q;
  assign crank.tooth_period  = tooth_period_q;

endmodule

// File: tb/tb_crank_decoder.sv
// Directed bench for crank_decoder: 36-1 wheel acquisition, position sequence,
// sync loss, stall, reset mid-revolution and (with CKP_GLITCH_FILTER_EN) glitches.
module tb_crank_decoder;

  localparam int TEETH    = 36;
  localparam int MISSING  = 1;
  localparam int PERIOD_W = 20;
  localparam int STALL    = 1000;
  localparam int DEB      = 4;
  localparam int POS_W    = $clog2(2 * TEETH);
`ifdef CKP_GLITCH_FILTER_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic ckp   = 1'b0;

  crank_decoder_if #(.TEETH(TEETH), .PERIOD_W(PERIOD_W)) cif ();

  crank_decoder #(
    .TEETH        (TEETH),
    .MISSING      (MISSING),
    .PERIOD_W     (PERIOD_W),
    .STALL_CYCLES (STALL),
    .DEB_CYCLES   (DEB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ckp   (ckp),
    .crank (cif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int               n_tick    = 0;
  int               n_changed = 0;
  int               n_err     = 0;
  logic [POS_W-1:0] last_pos  = '0;
  logic             last_sync = 1'b0;
  logic             last_err  = 1'b0;

  always @(negedge clk) begin
    if (cif.crank_tick) begin
      n_tick    <= n_tick + 1;
      last_pos  <= cif.crank_pos;
      last_sync <= cif.sync;
      last_err  <= cif.sync_err;
    end
    if (cif.crank_changed) n_changed <= n_changed + 1;
    if (cif.sync_err)      n_err     <= n_err + 1;
  end

  // Rising edge now, next rising edge p clock edges later.
  task automatic tooth(input int p);
    @(posedge clk); #1 ckp = 1'b1;
    repeat (19) @(posedge clk);
    #1 ckp = 1'b0;
    repeat (p - 20) @(posedge clk);
    #1;
  endtask

  // First edge after STOPPED: 5-cycle pulse, latency probed, 100-cycle interval.
  task automatic first_edge(input string tag);
    @(posedge clk); #1 ckp = 1'b1;
    for (int k = 0; k <= LAT + 1; k++) begin
      @(posedge clk); #1;
      if (k == LAT - 1) check({tag, "_tick_early"}, cif.crank_tick, 0);
      if (k == LAT)     check({tag, "_tick_latency"}, cif.crank_tick, 1);
      if (k == LAT + 1) check({tag, "_tick_width"}, cif.crank_tick, 0);
      if (k == 4) ckp = 1'b0;
    end
    repeat (97 - LAT) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tick"},    cif.crank_tick, 0);
    check({tag, "_changed"}, cif.crank_changed, 0);
    check({tag, "_pos"},     cif.crank_pos, 0);
    check({tag, "_sync"},    cif.sync, 0);
    check({tag, "_err"},     cif.sync_err, 0);
    check({tag, "_running"}, cif.running, 0);
    check({tag, "_period"},  cif.tooth_period, 0);
  endtask

  int t0, c0, e0, waited;

  initial begin
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

`ifdef CKP_GLITCH_FILTER_EN
    for (int g = 0; g < 3; g++) begin
      @(posedge clk); #1 ckp = 1'b1;
      repeat (3) @(posedge clk);
      #1 ckp = 1'b0;
      repeat (12) @(posedge clk);
      #1;
    end
    check("glitch_no_tick", n_tick, 0);
    check("glitch_running", cif.running, 0);
`endif

    // Scenario A: acquisition and two full revolutions.
    first_edge("acq");
    check("acq_running", cif.running, 1);
    tooth(200);
    check("acq_presync", cif.sync, 0);
    t0 = n_tick;
    c0 = n_changed;
    e0 = n_err;
    for (int i = 0; i < TEETH - MISSING; i++) begin
      tooth((i == TEETH - MISSING - 1) ? 200 : 100);
      check($sformatf("rev0_pos_%0d", i), last_pos, i);
      check($sformatf("rev0_sync_%0d", i), last_sync, 1);
    end
    for (int i = 0; i < TEETH - MISSING; i++) begin
      tooth((i == TEETH - MISSING - 1) ? 200 : 100);
      check($sformatf("rev1_pos_%0d", i), last_pos, TEETH + i);
    end
    tooth(100);
    check("wrap_pos", last_pos, 0);
    check("wrap_sync", last_sync, 1);
    check("ticks_two_revs", n_tick - t0, 71);
    check("changed_per_tick", n_changed - c0, n_tick - t0);
    check("no_err_steady", n_err, e0);

    // Scenario B: extra gap at tooth 10.
    for (int i = 1; i <= 9; i++) begin
      tooth((i == 9) ? 200 : 100);
      check($sformatf("b_pos_%0d", i), last_pos, i);
    end
    tooth(100);
    check("b_err_count", n_err, e0 + 1);
    check("b_err_at_edge", last_err, 1);
    check("b_sync_lost", cif.sync, 0);
    repeat (3) tooth(100);
    tooth(200);
    check("b_still_seeking", cif.sync, 0);
    tooth(100);
    check("b_relock_pos", last_pos, 0);
    check("b_relock_sync", last_sync, 1);
    check("b_err_once", n_err, e0 + 1);

    // Scenario C: gap removed, loss after tooth 34, then lock from SEEK_GAP.
    for (int i = 1; i < TEETH - MISSING; i++) begin
      tooth(100);
      check($sformatf("c_pos_%0d", i), last_pos, i);
    end
    tooth(200);
    check("c_err_count", n_err, e0 + 2);
    check("c_sync_lost", cif.sync, 0);
    check("c_running", cif.running, 1);
    tooth(100);
    check("c_relock_pos", last_pos, 0);
    check("c_relock_sync", cif.sync, 1);

    // Scenario D: edges stop.
    t0 = n_tick;
    waited = 0;
    while (cif.running && waited < 1200) begin
      @(posedge clk); #1;
      waited++;
    end
    check("stall_running", cif.running, 0);
    check("stall_not_early", waited > 800, 1);
    check("stall_sync", cif.sync, 0);
    check("stall_pos", cif.crank_pos, 0);
    check("stall_period", cif.tooth_period, 0);
    check("stall_no_err", n_err, e0 + 2);
    check("stall_no_tick", n_tick, t0);

    // Restart; an edge exactly at the stall count must win.
    first_edge("restart");
    tooth(STALL);
    tooth(100);
    check("coincide_running", cif.running, 1);
    check("coincide_period", cif.tooth_period, STALL);
    check("coincide_lock_pos", last_pos, 0);
    check("coincide_lock_sync", cif.sync, 1);
    for (int i = 1; i <= 3; i++) begin
      tooth(100);
      check($sformatf("e_pos_%0d", i), last_pos, i);
    end

    // Scenario E: asynchronous reset mid-revolution.
    #3 reset = 1'b1;
    #2 check_outputs_zero("midrev_reset");
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    first_edge("post_reset");
    check("post_reset_running", cif.running, 1);
    tooth(200);
    check("post_reset_presync", cif.sync, 0);
    tooth(100);
    check("post_reset_lock_pos", last_pos, 0);
    check("post_reset_lock_sync", cif.sync, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crank_decoder.md
# crank_decoder

Front-end crank-position stage of the HUST EFI pipeline. Conditions the raw CKP trigger-wheel signal, measures tooth periods and locates the missing-tooth gap. Produces the `crank_tick`/`crank_changed` strobes, tooth index and sync status consumed by the per-cylinder stroke-transition logic directly downstream.

## Interface
- `TEETH`, default `CFG_CRANK_TEETH` (36): physical tooth positions on the wheel, missing teeth included.
- `MISSING`, default 1: number of consecutive missing teeth.
- `PERIOD_W`, default 20: tooth-period counter width in clk cycles.
- `STALL_CYCLES`, default 2^20-1: period count at which the engine is declared stopped.
- `DEB_CYCLES`, default 4: glitch-filter depth.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset. This is already decided.
- `ckp` in 1: raw CKP sensor, asynchronous to clk.
- `crank_tick` out 1: one-cycle pulse per accepted rising tooth edge, regardless of sync.
- `crank_changed` out 1: one-cycle pulse whenever `crank_pos` updates; asserted only while synced.
- `crank_pos` out $clog2(2*TEETH): position over 720°, equal to rev*TEETH + tooth.
- `sync` out 1: gap locked and tooth count consistent.
- `sync_err` out 1: one-cycle pulse on loss of sync.
- `running` out 1: edges are arriving within `STALL_CYCLES`.
- `tooth_period` out PERIOD_W: last measured edge-to-edge period.

## Operation
- Input path: 2-flop synchronizer, then optional glitch filter, then rising-edge detect. Each accepted edge pulses `crank_tick`.
- `per_cnt` counts clk cycles since the last accepted edge and saturates at all-ones. On an edge: `tooth_period` ← `per_cnt`, `prev` ← old `tooth_period`, and `per_cnt` ← 1.
- Gap test: the edge is a gap when `cur*2 > prev*3`, i.e. ratio > 1.5. Evaluate it at PERIOD_W+2 bits with no overflow.
- FSM states: STOPPED, FIRST, SEEK_GAP, SYNCED.
  - STOPPED: on the first edge, go to FIRST and set `running`=1.
  - FIRST: on the next edge, the period is valid; go to SEEK_GAP.
  - SEEK_GAP: on a gap edge, set tooth=0, rev=0 and go to SYNCED; pulse `crank_changed`.
  - SYNCED, non-gap edge: tooth+1. If tooth was TEETH-MISSING-1, this is a missing expected gap.
  - SYNCED, gap edge: valid only when tooth==TEETH-MISSING-1. Then tooth=0, rev toggles, and `crank_changed` pulses.
  - SYNCED, unexpected gap or missing expected gap: pulse `sync_err`, set `sync`=0 and go to SEEK_GAP. The offending gap edge is not reused for acquisition.
- Stall: `per_cnt` reaching `STALL_CYCLES` in any state forces STOPPED. It clears `sync` and `running` and zeroes `crank_pos` and `tooth_period`. No `sync_err` is raised.
- `sync`=1 exactly while the FSM is in SYNCED.

## Timing
- Reset values: all outputs 0, FSM in STOPPED, counters 0. Reset takes effect immediately, including mid-revolution.
- Edge latency:
  - Without the filter: `crank_tick` is high in cycle 3 after the first clk edge that samples `ckp`=1.
  - With the filter: add DEB_CYCLES.
- `crank_changed`, `crank_pos`, `sync`, `sync_err` and `tooth_period` update in the same cycle as `crank_tick`. All outputs are registered.
- If an edge and the stall threshold coincide, the edge wins and no stall occurs.
- `crank_pos` wraps from 2*TEETH-MISSING-1 to 0 at the gap following rev=1.

## Configuration
- `CKP_GLITCH_FILTER_EN`, when defined: the synchronized level is accepted only after DEB_CYCLES consecutive equal samples. Pulses shorter than DEB_CYCLES never produce edges.
- When undefined: the synchronized signal feeds the edge detector directly, and the DEB_CYCLES parameter is ignored.

## Structure
- The FSM state enum `crank_state_t` and the gap-ratio constants (3/2) go in the shared `hust_efi_pkg`.
- `CFG_CRANK_TEETH` goes in `hust_efi_defines.vh`.
- One sub-module, `ckp_edge_filter`: synchronizer, optional filter and rising-edge pulse.

## Test plan
All scenarios use TEETH=36, MISSING=1 and DEB_CYCLES=4.
- Steady wheel, 100-cycle teeth, 200-cycle gap:
  - `sync` rises at the first gap edge with `crank_pos`=0.
  - `crank_pos` counts 0..34, then 36..70, then wraps to 0.
  - One `crank_changed` per `crank_tick`.
- Extra gap injected at tooth 10 → `sync_err` one pulse, `sync`=0; re-lock at the next gap with `crank_pos`=0.
- Gap removed (all periods 100) → `sync_err` at the edge after tooth 34; FSM in SEEK_GAP.
- Edges stop → `running`=0, `sync`=0 and `crank_pos`=0 when `per_cnt` hits STALL_CYCLES; no `sync_err`.
- With the filter: 3-cycle glitch pulses on `ckp` → no `crank_tick`. A 5-cycle pulse → `crank_tick` at cycle 3+4.
- Reset asserted mid-revolution → all outputs 0 within the same cycle; acquisition restarts from STOPPED.
